axi_write_sequencer: RTL and testbench

Command-driven AXI4 write master that replaces hand-coded, counter-timed channel pokes on a crossbar slave port (e.g. `slave[0]`). It buffers single-beat write commands (address, data, strobe, size) in a small FIFO. Each command is issued as a protocol-correct AW/W pair, and the sequencer waits for the B response before issuing the next. It sits directly upstream of `axi_xbar_intf` and programs the accelerator register map (0x5000_0010 address, 0x5000_0020 wdata, 0x5000_0028 start) or DRAM.

---
 rtl/axi_write_sequencer_if.sv | 90 +++++++++
 rtl/axi_write_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_write_sequencer.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_sequencer_if.sv
// AXI4 bus bundle shared by the write sequencer and the crossbar slave port.
// The master view drives requests; the slave view drives ready and response signals.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 64
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_write_sequencer.sv
// Command-driven AXI4 single-beat write master. Commands are queued in a small FIFO and
// issued one at a time as an AW/W pair; the next command waits for the B response.
module axi_write_sequencer #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 64,
    parameter int unsigned AXI_ID         = 0,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_strb_i,
    input  logic [2:0]                  cmd_size_i,
    AXI_BUS.Master                      axi_master_port,
    output logic                        busy_o,
    output logic                        wr_done_o,
    output logic [31:0]                 wr_count_o,
    output logic [15:0]                 err_count_o,
    output logic                        timeout_o
);
    localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;
    localparam int unsigned PtrWidth  = $clog2(FIFO_DEPTH);
    localparam int unsigned TmoWidth  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [PtrWidth:0]   PtrOne   = 1;
    localparam logic [TmoWidth-1:0] TmoOne   = 1;
    localparam logic [TmoWidth-1:0] TmoLimit = TmoWidth'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSend, StResp} state_e;

    // Command FIFO; pointers carry one extra bit to tell full from empty.
    logic [AXI_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [AXI_DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [StrbWidth-1:0]      r_fifo_strb [FIFO_DEPTH];
    logic [2:0]                r_fifo_size [FIFO_DEPTH];
    logic [PtrWidth:0]         r_wptr;
    logic [PtrWidth:0]         r_rptr;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [PtrWidth-1:0] w_wr_idx;
    logic [PtrWidth-1:0] w_rd_idx;

    // Sequencer state and registered AXI outputs.
    state_e                    r_state;
    logic                      r_aw_valid;
    logic                      r_w_valid;
    logic                      r_b_ready;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
    logic [2:0]                r_aw_size;
    logic [AXI_DATA_WIDTH-1:0] r_w_data;
    logic [StrbWidth-1:0]      r_w_strb;
    logic                      r_wr_done;
    logic [31:0]               r_wr_count;
    logic [15:0]               r_err_count;
    logic [TmoWidth-1:0]       r_tmo_cnt;
    logic                      r_timeout;

    logic                w_aw_done;
    logic                w_w_done;
    logic [TmoWidth-1:0] w_tmo_inc;

    assign w_wr_idx = r_wptr[PtrWidth-1:0];
    assign w_rd_idx = r_rptr[PtrWidth-1:0];
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PtrWidth] != r_rptr[PtrWidth]) &&
                      (r_wptr[PtrWidth-1:0] == r_rptr[PtrWidth-1:0]);
    assign w_push   = cmd_valid_i && !w_full;
    assign w_pop    = (r_state == StIdle) && !w_empty;

    // A channel counts as done once its valid has dropped or it handshakes this cycle.
    assign w_aw_done = !r_aw_valid || axi_master_port.aw_ready;
    assign w_w_done  = !r_w_valid || axi_master_port.w_ready;
    assign w_tmo_inc = r_tmo_cnt + TmoOne;

    // Store accepted commands; storage needs no reset since pointers gate its use.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[w_wr_idx] <= cmd_addr_i;
            r_fifo_data[w_wr_idx] <= cmd_data_i;
            r_fifo_strb[w_wr_idx] <= cmd_strb_i;
            r_fifo_size[w_wr_idx] <= cmd_size_i;
        end
    end

    // Advance FIFO pointers on push and pop; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrOne;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrOne;
            end
        end
    end

    // Issue one write at a time: load AW/W, wait for both handshakes, then collect B.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_aw_addr   <= '0;
            r_aw_size   <= '0;
            r_w_data    <= '0;
            r_w_strb    <= '0;
            r_wr_done   <= 1'b0;
            r_wr_count  <= '0;
            r_err_count <= '0;
            r_tmo_cnt   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;

            // The watchdog only flags a stall; valid can never be withdrawn.
            if (r_state != StIdle && r_tmo_cnt != TmoLimit) begin
                r_tmo_cnt <= w_tmo_inc;
                if (w_tmo_inc == TmoLimit) begin
                    r_timeout <= 1'b1;
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_aw_addr  <= r_fifo_addr[w_rd_idx];
                        r_aw_size  <= r_fifo_size[w_rd_idx];
                        r_w_data   <= r_fifo_data[w_rd_idx];
                        r_w_strb   <= r_fifo_strb[w_rd_idx];
                        r_aw_valid <= 1'b1;
                        r_w_valid  <= 1'b1;
                        r_tmo_cnt  <= '0;
                        r_state    <= StSend;
                    end
                end
                StSend: begin
                    if (axi_master_port.aw_ready) begin
                        r_aw_valid <= 1'b0;
                    end
                    if (axi_master_port.w_ready) begin
                        r_w_valid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_b_ready <= 1'b1;
                        r_state   <= StResp;
                    end
                end
                StResp: begin
                    if (axi_master_port.b_valid) begin
                        r_b_ready  <= 1'b0;
                        r_wr_done  <= 1'b1;
                        r_wr_count <= r_wr_count + 32'd1;
                        if (axi_master_port.b_resp != 2'b00 && r_err_count != 16'hFFFF) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o = !w_full;
    assign busy_o      = !w_empty || (r_state != StIdle);
    assign wr_done_o   = r_wr_done;
    assign wr_count_o  = r_wr_count;
    assign err_count_o = r_err_count;
    assign timeout_o   = r_timeout;

    // Write address channel: single-beat INCR, all sideband fields zero.
    assign axi_master_port.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master_port.aw_addr   = r_aw_addr;
    assign axi_master_port.aw_len    = 8'd0;
    assign axi_master_port.aw_size   = r_aw_size;
    assign axi_master_port.aw_burst  = 2'b01;
    assign axi_master_port.aw_lock   = 1'b0;
    assign axi_master_port.aw_cache  = 4'd0;
    assign axi_master_port.aw_prot   = 3'd0;
    assign axi_master_port.aw_qos    = 4'd0;
    assign axi_master_port.aw_region = 4'd0;
    assign axi_master_port.aw_atop   = 6'd0;
    assign axi_master_port.aw_user   = '0;
    assign axi_master_port.aw_valid  = r_aw_valid;

    assign axi_master_port.w_data  = r_w_data;
    assign axi_master_port.w_strb  = r_w_strb;
    assign axi_master_port.w_last  = 1'b1;
    assign axi_master_port.w_user  = '0;
    assign axi_master_port.w_valid = r_w_valid;

    assign axi_master_port.b_ready = r_b_ready;

    // Read channels are never used: no requests, and any stray data is drained.
    assign axi_master_port.ar_id     = '0;
    assign axi_master_port.ar_addr   = '0;
    assign axi_master_port.ar_len    = 8'd0;
    assign axi_master_port.ar_size   = 3'd0;
    assign axi_master_port.ar_burst  = 2'b00;
    assign axi_master_port.ar_lock   = 1'b0;
    assign axi_master_port.ar_cache  = 4'd0;
    assign axi_master_port.ar_prot   = 3'd0;
    assign axi_master_port.ar_qos    = 4'd0;
    assign axi_master_port.ar_region = 4'd0;
    assign axi_master_port.ar_user   = '0;
    assign axi_master_port.ar_valid  = 1'b0;
    assign axi_master_port.r_ready   = 1'b1;

    logic w_unused;
    assign w_unused = ^{axi_master_port.b_id, axi_master_port.b_user, axi_master_port.ar_ready,
                        axi_master_port.r_id, axi_master_port.r_data, axi_master_port.r_resp,
                        axi_master_port.r_last, axi_master_port.r_user,
                        axi_master_port.r_valid};
endmodule

// File: tb/tb_axi_write_sequencer.sv
// Bench for axi_write_sequencer: scoreboard of expected AW/W beats filled on command push
// and drained by a bus monitor, plus per-scenario timing and counter checks.
module tb_axi_write_sequencer;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 64;
    localparam int unsigned SW = DW / 8;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [2:0]  size;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_size = '0;
    logic          busy;
    logic          wr_done;
    logic [31:0]   wr_count;
    logic [15:0]   err_count;
    logic          timeout;

    AXI_BUS #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH  (IW),
        .AXI_USER_WIDTH(UW)
    ) bus ();

    axi_write_sequencer #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH  (IW),
        .AXI_USER_WIDTH(UW),
        .AXI_ID        (0),
        .FIFO_DEPTH    (4),
        .TIMEOUT       (10)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_addr_i     (cmd_addr),
        .cmd_data_i     (cmd_data),
        .cmd_strb_i     (cmd_strb),
        .cmd_size_i     (cmd_size),
        .axi_master_port(bus),
        .busy_o         (busy),
        .wr_done_o      (wr_done),
        .wr_count_o     (wr_count),
        .err_count_o    (err_count),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail = 0;
    cmd_t exp_aw[$];
    cmd_t exp_w[$];
    int   aw_hs = 0;
    int   w_hs = 0;
    int   b_hs = 0;
    int   done_cnt = 0;
    bit   inflight = 1'b0;

    // Slave B responder controls.
    bit         b_hold = 1'b0;
    int         b_delay = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    int         b_wait = 0;

    // B responder: raises b_valid b_delay cycles after b_ready, unless held.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n || !bus.b_ready) begin
            bus.b_valid = 1'b0;
            b_wait = 0;
        end else begin
            if (!b_hold && b_wait >= b_delay) begin
                bus.b_valid = 1'b1;
                bus.b_resp  = b_resp_cfg;
            end else begin
                bus.b_valid = 1'b0;
            end
            b_wait++;
        end
    end

    // Bus monitor: handshakes sampled mid-cycle, checked against the scoreboard.
    always @(negedge clk) begin
        cmd_t e;
        if (rst_n) begin
            if (bus.aw_valid && bus.aw_ready) begin
                aw_hs++;
                n_tests++;
                if (inflight) begin
                    n_fail++;
                    $display("FAIL aw_overlap: AW at addr %h while a write is outstanding",
                             bus.aw_addr);
                end
                inflight = 1'b1;
                n_tests++;
                if (exp_aw.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_unexpected: got addr %h, expected no AW", bus.aw_addr);
                end else begin
                    e = exp_aw.pop_front();
                    if ({bus.aw_addr, bus.aw_size} !== {e.addr, e.size}) begin
                        n_fail++;
                        $display("FAIL aw_fields: got addr %h size %0d, expected addr %h size %0d",
                                 bus.aw_addr, bus.aw_size, e.addr, e.size);
                    end
                end
                n_tests++;
                if ({bus.aw_len, bus.aw_burst, bus.aw_id, bus.aw_cache, bus.aw_prot,
                     bus.aw_atop, bus.aw_lock} !== {8'd0, 2'b01, 4'd0, 4'd0, 3'd0, 6'd0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL aw_const: got len %0d burst %0d id %0d, expected 0/1/0",
                             bus.aw_len, bus.aw_burst, bus.aw_id);
                end
            end
            if (bus.w_valid && bus.w_ready) begin
                w_hs++;
                n_tests++;
                if (exp_w.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_unexpected: got data %h, expected no W", bus.w_data);
                end else begin
                    e = exp_w.pop_front();
                    if ({bus.w_data, bus.w_strb, bus.w_last} !== {e.data, e.strb, 1'b1}) begin
                        n_fail++;
                        $display("FAIL w_fields: got data %h strb %h last %b, expected %h %h 1",
                                 bus.w_data, bus.w_strb, bus.w_last, e.data, e.strb);
                    end
                end
            end
            if (bus.b_valid && bus.b_ready) begin
                b_hs++;
                inflight = 1'b0;
            end
            if (wr_done) begin
                done_cnt++;
            end
            n_tests++;
            if (bus.b_ready && (bus.aw_valid || bus.w_valid)) begin
                n_fail++;
                $display("FAIL b_ready_early: got b_ready=1 with aw_valid=%b w_valid=%b, expected 0",
                         bus.aw_valid, bus.w_valid);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        bus.aw_ready  = 1'b1;
        bus.w_ready   = 1'b1;
        b_hold        = 1'b0;
        b_delay       = 0;
        b_resp_cfg    = 2'b00;
        tick(2);
        exp_aw.delete();
        exp_w.delete();
        inflight = 1'b0;
        aw_hs    = 0;
        w_hs     = 0;
        b_hs     = 0;
        done_cnt = 0;
        rst_n    = 1'b1;
    endtask

    // Present a command until accepted; the scoreboard entry is queued at acceptance.
    task automatic push_cmd(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [2:0] z);
        cmd_t c;
        bit   ok = 1'b0;
        c.addr = a;
        c.data = d;
        c.strb = s;
        c.size = z;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_strb  = s;
        cmd_size  = z;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_aw.push_back(c);
                exp_w.push_back(c);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: got cmd_ready=0 for 400 cycles, expected acceptance");
        end
    endtask

    task automatic wait_done(input int target);
        int i = 0;
        while (done_cnt < target && i < 500) begin
            tick();
            i++;
        end
        n_tests++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL done_timeout: got %0d completions, expected %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cmd_ready, busy, wr_done, timeout} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/busy/done/tmo %b%b%b%b, expected 1000",
                     cmd_ready, busy, wr_done, timeout);
        end
        n_tests++;
        if ({wr_count, err_count} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got wr %0d err %0d, expected 0 0", wr_count, err_count);
        end
        n_tests++;
        if ({bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_axi: got aw/w/b/ar/r %b%b%b%b%b, expected 00001", bus.aw_valid,
                     bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        push_cmd(64'h5000_0010, 64'h9000_0004, 8'hFF, 3'd2);
        n_tests++;
        if ({bus.aw_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_e0: got aw_valid %b busy %b, expected 0 1", bus.aw_valid, busy);
        end
        tick();
        n_tests++;
        if ({bus.aw_valid, bus.w_valid, bus.b_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL single_e1: got aw/w/b %b%b%b, expected 110", bus.aw_valid,
                     bus.w_valid, bus.b_ready);
        end
        tick();
        n_tests++;
        if ({aw_hs, w_hs} !== {32'd1, 32'd1} ||
            {bus.aw_valid, bus.w_valid, bus.b_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_e2: got hs %0d/%0d aw/w/b %b%b%b, expected 1/1 001", aw_hs,
                     w_hs, bus.aw_valid, bus.w_valid, bus.b_ready);
        end
        tick();
        n_tests++;
        if ({wr_done, bus.b_ready} !== 2'b10 || wr_count !== 32'd1) begin
            n_fail++;
            $display("FAIL single_e3: got done %b b_ready %b count %0d, expected 1 0 1", wr_done,
                     bus.b_ready, wr_count);
        end
        tick();
        n_tests++;
        if ({wr_done, busy} !== 2'b00 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_after: got done %b busy %b pulses %0d, expected 0 0 1", wr_done,
                     busy, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_cmd(64'h5000_0010, 64'h9000_0004, 8'hFF, 3'd3);
        push_cmd(64'h5000_0020, 64'h2424_4242, 8'hFF, 3'd3);
        push_cmd(64'h5000_0028, 64'h1, 8'h0F, 3'd2);
        wait_done(3);
        tick(2);
        n_tests++;
        if ({wr_count, err_count} !== {32'd3, 16'd0} || aw_hs !== 3 || exp_aw.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_counts: got wr %0d err %0d aw %0d left %0d, expected 3 0 3 0",
                     wr_count, err_count, aw_hs, exp_aw.size());
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_split_handshake();
        do_reset();
        bus.aw_ready = 1'b0;
        push_cmd(64'h5000_0020, 64'hDEAD_BEEF, 8'hF0, 3'd3);
        tick();
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (bus.aw_valid !== 1'b1 || bus.aw_addr !== 64'h5000_0020 ||
                bus.w_valid !== (k == 0) || bus.b_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL split_hold%0d: got aw %b addr %h w %b b %b, expected 1 50000020 %b 0",
                         k, bus.aw_valid, bus.aw_addr, bus.w_valid, bus.b_ready, (k == 0));
            end
            if (k == 5) begin
                bus.aw_ready = 1'b1;
            end
            tick();
        end
        n_tests++;
        if ({bus.aw_valid, bus.b_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL split_resp: got aw %b b_ready %b, expected 0 1", bus.aw_valid,
                     bus.b_ready);
        end
        wait_done(1);
        n_tests++;
        if (wr_count !== 32'd1) begin
            n_fail++;
            $display("FAIL split_count: got %0d, expected 1", wr_count);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        b_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_cmd(64'h8000_1000 + 64'(i * 8), 64'hA5A5_0000 + 64'(i), 8'hFF, 3'd3);
        end
        n_tests++;
        if ({cmd_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_ready: got ready %b busy %b, expected 0 1", cmd_ready, busy);
        end
        cmd_addr  = 64'h8000_1028;
        cmd_data  = 64'hA5A5_0005;
        cmd_valid = 1'b1;
        tick(8);
        n_tests++;
        if (cmd_ready !== 1'b0 || wr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL full_held: got ready %b count %0d, expected 0 0", cmd_ready, wr_count);
        end
        b_hold = 1'b0;
        push_cmd(64'h8000_1028, 64'hA5A5_0005, 8'hFF, 3'd3);
        n_tests++;
        if (wr_count !== 32'd1) begin
            n_fail++;
            $display("FAIL full_6th: got count %0d at acceptance, expected 1", wr_count);
        end
        wait_done(6);
        tick(2);
        n_tests++;
        if (wr_count !== 32'd6 || aw_hs !== 6 || exp_w.size() !== 0) begin
            n_fail++;
            $display("FAIL full_all: got count %0d aw %0d left %0d, expected 6 6 0", wr_count,
                     aw_hs, exp_w.size());
        end
    endtask

    task automatic test_error_timeout();
        do_reset();
        b_resp_cfg = 2'b10;
        push_cmd(64'h5000_0010, 64'h1234, 8'h03, 3'd1);
        wait_done(1);
        tick();
        n_tests++;
        if (err_count !== 16'd1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL err_slverr: got err %0d tmo %b, expected 1 0", err_count, timeout);
        end
        b_resp_cfg = 2'b00;
        b_delay    = 20;
        push_cmd(64'h5000_0028, 64'h1, 8'h01, 3'd0);
        tick(6);
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_early: got %b after 5 busy cycles, expected 0", timeout);
        end
        wait_done(2);
        n_tests++;
        if (timeout !== 1'b1 || wr_count !== 32'd2 || err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL tmo_set: got tmo %b count %0d err %0d, expected 1 2 1", timeout,
                     wr_count, err_count);
        end
        b_delay = 0;
        tick(3);
        n_tests++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_sticky: got %b, expected 1", timeout);
        end
    endtask

    task automatic test_reset_mid_send();
        int aw_before;
        do_reset();
        push_cmd(64'h5000_0010, 64'h77, 8'hFF, 3'd3);
        wait_done(1);
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        push_cmd(64'h9000_0000, 64'h88, 8'hFF, 3'd3);
        push_cmd(64'h9000_0008, 64'h99, 8'hFF, 3'd3);
        n_tests++;
        if (bus.aw_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got aw_valid %b, expected 1", bus.aw_valid);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({bus.aw_valid, bus.w_valid, bus.b_ready, busy, cmd_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL rst_mid_axi: got aw/w/b/busy/ready %b%b%b%b%b, expected 00001",
                     bus.aw_valid, bus.w_valid, bus.b_ready, busy, cmd_ready);
        end
        n_tests++;
        if ({wr_count, err_count} !== 48'd0) begin
            n_fail++;
            $display("FAIL rst_mid_counts: got wr %0d err %0d, expected 0 0", wr_count,
                     err_count);
        end
        exp_aw.delete();
        exp_w.delete();
        inflight     = 1'b0;
        aw_before    = aw_hs;
        bus.aw_ready = 1'b1;
        bus.w_ready  = 1'b1;
        rst_n        = 1'b1;
        tick(10);
        n_tests++;
        if (aw_hs !== aw_before || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_replay: got %0d new AW busy %b, expected 0 0",
                     aw_hs - aw_before, busy);
        end
    endtask

    initial begin
        bus.b_id     = '0;
        bus.b_user   = '0;
        bus.ar_ready = 1'b0;
        bus.r_id     = '0;
        bus.r_data   = '0;
        bus.r_resp   = 2'b00;
        bus.r_last   = 1'b0;
        bus.r_user   = '0;
        bus.r_valid  = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_split_handshake();
        test_fifo_full();
        test_error_timeout();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
